// File: rtl/lsu_mem_req_pkg.sv
// Shared types and codes for the MEM-stage load/store request unit.
// Size and extension encodings must match the decode stage and the load-data extender.
package lsu_mem_req_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    localparam logic [2:0] RAM_EXT_W  = 3'd0;
    localparam logic [2:0] RAM_EXT_B  = 3'd1;
    localparam logic [2:0] RAM_EXT_BU = 3'd2;
    localparam logic [2:0] RAM_EXT_H  = 3'd3;
    localparam logic [2:0] RAM_EXT_HU = 3'd4;

    // Size code 11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LSU_SIZE_H) && off[0]) ||
               (((size == LSU_SIZE_W) || (size == 2'b11)) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_req_if.sv
// Data-RAM request/response bus: the unit is the master, the RAM controller the slave.
interface lsu_mem_req_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/lsu_mem_req_store_align.sv
// Combinational store lane steering: byte strobes and lane-replicated write data.
module lsu_store_align
    import lsu_mem_req_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep
);
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign wstrb[gi] = (size == LSU_SIZE_B) ? (offset == LANE) :
                               (size == LSU_SIZE_H) ? (offset[1] == LANE[1]) : 1'b1;
            assign wdata_rep[8*gi +: 8] = (size == LSU_SIZE_B) ? wdata[7:0] :
                                          (size == LSU_SIZE_H) ? wdata[8*(gi%2) +: 8] :
                                                                 wdata[8*gi +: 8];
        end
    endgenerate
endmodule

// File: rtl/lsu_mem_req.sv
// MEM-stage load/store request unit: issues one bus transaction per memory op,
// stalls the pipeline while it is in flight and hands the raw read word to the extender.
module lsu_mem_req
    import lsu_mem_req_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int RESP_FIFO_FREE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [1:0]        ex_size,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [2:0]        ex_ext_op,
    input  logic              flush,
    lsu_mem_req_if.master     bus,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic              ale,
    output logic [31:0]       ld_din,
    output logic [1:0]        ld_byte_offset,
    output logic [2:0]        ld_ext_op
);
    // Only single-outstanding operation exists; any other setting never issues.
    localparam bit SINGLE_OUTSTANDING = (RESP_FIFO_FREE == 0);

    lsu_state_e        state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        ext_q, ext_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       ld_din_q, ld_din_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [2:0]        ld_ext_q, ld_ext_d;

    logic        misaligned, idle_op, accept;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;

    lsu_store_align u_align (
        .size      (ex_size),
        .offset    (ex_addr[1:0]),
        .wdata     (ex_wdata),
        .wstrb     (align_wstrb),
        .wdata_rep (align_wdata)
    );

    // done_q keeps the just-completed op, still visible on ex_*, from issuing twice.
    assign misaligned = is_misaligned(ex_size, ex_addr[1:0]);
    assign idle_op    = (state_q == LSU_IDLE) && ex_valid && !flush && !done_q;
    assign accept     = idle_op && !misaligned && SINGLE_OUTSTANDING;
    assign ale        = idle_op && misaligned;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        done_d   = 1'b0;
        wr_d     = wr_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ext_d    = ext_q;
        off_d    = off_q;
        ld_din_d = ld_din_q;
        ld_off_d = ld_off_q;
        ld_ext_d = ld_ext_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    state_d = LSU_REQ;
                    wr_d    = ex_we;
                    wstrb_d = ex_we ? align_wstrb : 4'b0000;
                    addr_d  = ex_addr;
                    wdata_d = align_wdata;
                    ext_d   = ex_ext_op;
                    off_d   = ex_addr[1:0];
                end
            end
            LSU_REQ: begin
                if (flush) cancel_d = 1'b1;
                if (bus.data_addr_ok) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                if (flush) cancel_d = 1'b1;
                // Response ends the transaction; a flushed op drains silently.
                if (bus.data_data_ok) begin
                    state_d  = LSU_IDLE;
                    cancel_d = 1'b0;
                    if (!cancel_q) begin
                        done_d = 1'b1;
                        if (!wr_q) begin
                            ld_din_d = bus.data_rdata;
                            ld_off_d = off_q;
                            ld_ext_d = ext_q;
                        end
                    end
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LSU_IDLE;
            cancel_q <= 1'b0;
            done_q   <= 1'b0;
            wr_q     <= 1'b0;
            wstrb_q  <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            ext_q    <= '0;
            off_q    <= '0;
            ld_din_q <= '0;
            ld_off_q <= '0;
            ld_ext_q <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            done_q   <= done_d;
            wr_q     <= wr_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ext_q    <= ext_d;
            off_q    <= off_d;
            ld_din_q <= ld_din_d;
            ld_off_q <= ld_off_d;
            ld_ext_q <= ld_ext_d;
        end
    end

    assign bus.data_req   = (state_q == LSU_REQ);
    assign bus.data_wr    = wr_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

    assign lsu_stall      = (state_q != LSU_IDLE) || accept;
    assign lsu_done       = done_q;
    assign ld_din         = ld_din_q;
    assign ld_byte_offset = ld_off_q;
    assign ld_ext_op      = ld_ext_q;
endmodule

// File: tb/tb_lsu_mem_req.sv
// Self-checking bench for lsu_mem_req: directed vector table, hand sequences
// for flush/reset corners, and random ops against a transaction-level model.
module tb_lsu_mem_req;
    import lsu_mem_req_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_we = 1'b0, flush = 1'b0;
    logic [1:0]  ex_size = 2'b00;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [2:0]  ex_ext_op = '0;
    logic        lsu_stall, lsu_done, ale;
    logic [31:0] ld_din;
    logic [1:0]  ld_byte_offset;
    logic [2:0]  ld_ext_op;

    lsu_mem_req_if #(.ADDR_W(32)) bus ();

    lsu_mem_req #(.ADDR_W(32), .RESP_FIFO_FREE(0)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_we(ex_we), .ex_size(ex_size),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_ext_op(ex_ext_op), .flush(flush),
        .bus(bus), .lsu_stall(lsu_stall), .lsu_done(lsu_done), .ale(ale),
        .ld_din(ld_din), .ld_byte_offset(ld_byte_offset), .ld_ext_op(ld_ext_op)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int txn_no = 0;

    // Model of the extender-facing state: last uncancelled load.
    logic [31:0] m_din = '0;
    logic [1:0]  m_off = '0;
    logic [2:0]  m_ext = '0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ext;
        int          aok;
        int          dok;
        logic [31:0] rdata;
        bit          fl;
        bit          exp_ale;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (txn %0d, t=%0t)", name, act, exp, txn_no, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mdl_mis(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd1) return off[0];
        if (sz >= 2'd2) return off != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] mdl_strb(input logic we, input logic [1:0] sz, input logic [1:0] off);
        if (!we) return 4'h0;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << off);
        return 4'hf;
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return {4{w[7:0]}};
        if (sz == 2'd1) return {2{w[15:0]}};
        return w;
    endfunction

    // Runs one op from an idle, non-done cycle; bus responses after aok/dok idle cycles.
    task automatic do_txn(input vec_t v);
        int dw;
        txn_no++;
        $display("[TB] txn %0d we=%0d size=%0d addr=%08h aok=%0d dok=%0d flush=%0d",
                 txn_no, v.we, v.size, v.addr, v.aok, v.dok, v.fl);
        dw = (v.fl && v.dok == 0) ? 1 : v.dok;
        ex_valid = 1'b1; ex_we = v.we; ex_size = v.size; ex_addr = v.addr;
        ex_wdata = v.wdata; ex_ext_op = v.ext; flush = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        #1;
        chk("ale", ale, v.exp_ale);
        if (v.exp_ale) begin
            chk("stall_misaligned", lsu_stall, 0);
            tick();
            chk("req_misaligned", bus.data_req, 0);
            ex_valid = 1'b0;
            return;
        end
        chk("stall_c0", lsu_stall, 1);
        chk("req_c0", bus.data_req, 0);
        tick();
        for (int i = 0; i <= v.aok; i++) begin
            bus.data_addr_ok = (i == v.aok);
            #1;
            chk("req_hold", bus.data_req, 1);
            chk("wr", bus.data_wr, v.we);
            chk("addr", bus.data_addr, v.addr);
            chk("wstrb", bus.data_wstrb, v.exp_wstrb);
            if (v.we) chk("wdata", bus.data_wdata, v.exp_wdata);
            chk("stall_req", lsu_stall, 1);
            chk("done_req", lsu_done, 0);
            tick();
        end
        bus.data_addr_ok = 1'b0;
        for (int i = 0; i <= dw; i++) begin
            if (v.fl && i == 0) begin flush = 1'b1; ex_valid = 1'b0; end
            else flush = 1'b0;
            bus.data_data_ok = (i == dw);
            bus.data_rdata = (i == dw) ? v.rdata : $urandom;
            #1;
            chk("req_wait", bus.data_req, 0);
            chk("stall_wait", lsu_stall, 1);
            chk("done_wait", lsu_done, 0);
            tick();
        end
        flush = 1'b0; bus.data_data_ok = 1'b0;
        if (!v.fl && !v.we) begin
            m_din = v.rdata; m_off = v.addr[1:0]; m_ext = v.ext;
        end
        #1;
        chk("done", lsu_done, !v.fl);
        chk("stall_done", lsu_stall, 0);
        chk("req_done", bus.data_req, 0);
        chk("ld_din", ld_din, m_din);
        chk("ld_byte_offset", ld_byte_offset, m_off);
        chk("ld_ext_op", ld_ext_op, m_ext);
        ex_valid = 1'b0;
        // A flushed op leaves no done pulse, so the next op may start right here.
        if (!v.fl) begin
            tick();
            chk("done_single", lsu_done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t r;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        vecs[0] = '{1'b0, 2'd0, 32'h0000_1003, 32'h0, RAM_EXT_B, 0, 0, 32'hAABB_CCDD, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[1] = '{1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, RAM_EXT_W, 0, 0, 32'h0, 1'b0, 1'b0, 4'b1100, 32'h1234_1234};
        vecs[2] = '{1'b0, 2'd2, 32'h0000_3001, 32'h0, RAM_EXT_W, 0, 0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0};
        vecs[3] = '{1'b1, 2'd2, 32'h0000_4000, 32'hDEAD_BEEF, RAM_EXT_W, 5, 0, 32'h0, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 2'd1, 32'h0000_5002, 32'h0, RAM_EXT_H, 1, 2, 32'h1122_3344, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[5] = '{1'b0, 2'd2, 32'h0000_6000, 32'h0, RAM_EXT_W, 0, 2, 32'h5555_5555, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_7001, 32'h0000_00A5, RAM_EXT_W, 0, 1, 32'h0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5};
        vecs[7] = '{1'b1, 2'd1, 32'h0000_8001, 32'h0000_BEEF, RAM_EXT_HU, 0, 0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0};

        #1;
        chk("rst_req", bus.data_req, 0);
        chk("rst_wr", bus.data_wr, 0);
        chk("rst_wstrb", bus.data_wstrb, 0);
        chk("rst_addr", bus.data_addr, 0);
        chk("rst_wdata", bus.data_wdata, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_stall", lsu_stall, 0);
        chk("rst_ld_din", ld_din, 0);
        chk("rst_ld_off", ld_byte_offset, 0);
        chk("rst_ld_ext", ld_ext_op, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tick();

        foreach (vecs[i]) do_txn(vecs[i]);

        // Flush in IDLE blocks acceptance.
        ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'd2; ex_addr = 32'h0000_A000; flush = 1'b1;
        #1;
        chk("flush_idle_stall", lsu_stall, 0);
        chk("flush_idle_ale", ale, 0);
        tick();
        chk("flush_idle_req", bus.data_req, 0);
        ex_valid = 1'b0; flush = 1'b0;
        tick();

        // Asynchronous reset in the middle of WAIT.
        ex_valid = 1'b1; ex_we = 1'b1; ex_size = 2'd2; ex_addr = 32'h0000_9000; ex_wdata = 32'h0BAD_F00D;
        tick();
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        #2;
        ex_valid = 1'b0; rst = 1'b1;
        #1;
        m_din = '0; m_off = '0; m_ext = '0;
        chk("arst_req", bus.data_req, 0);
        chk("arst_wr", bus.data_wr, 0);
        chk("arst_wstrb", bus.data_wstrb, 0);
        chk("arst_addr", bus.data_addr, 0);
        chk("arst_wdata", bus.data_wdata, 0);
        chk("arst_stall", lsu_stall, 0);
        chk("arst_done", lsu_done, 0);
        chk("arst_ld_din", ld_din, 0);
        #3;
        rst = 1'b0;
        tick();
        r = '{1'b0, 2'd0, 32'h0000_B002, 32'h0, RAM_EXT_BU, 0, 0, 32'hCAFE_0042, 1'b0, 1'b0, 4'b0000, 32'h0};
        do_txn(r);

        // Random ops against the model.
        for (int n = 0; n < 40; n++) begin
            r.we    = 1'($urandom);
            r.size  = 2'($urandom_range(0, 3));
            r.addr  = $urandom;
            r.wdata = $urandom;
            r.ext   = 3'($urandom_range(0, 4));
            r.aok   = $urandom_range(0, 3);
            r.dok   = $urandom_range(0, 3);
            r.rdata = $urandom;
            r.exp_ale   = mdl_mis(r.size, r.addr[1:0]);
            r.fl        = !r.exp_ale && ($urandom_range(0, 4) == 0);
            r.exp_wstrb = mdl_strb(r.we, r.size, r.addr[1:0]);
            r.exp_wdata = mdl_wdata(r.size, r.wdata);
            do_txn(r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
